axi_lite_cmd_master: RTL and testbench

// - AXI4-Lite initiator: turns single-beat register commands from a local sequencer/CPU-less config engine into
//   AXI4-Lite transactions toward register slaves on the same 16-bit address / 32-bit data s_axi fabric.
// - One outstanding transaction; bus-hang timeout returns an error response instead of locking the requester.

---
 rtl/axi_lite_cmd_master_if.sv | 57 +++++
 rtl/axi_lite_cmd_master.sv | 156 +++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
// 16-bit byte address, 32-bit data, single outstanding transaction.
// Modports:
//   master - drives AW/W/AR valids + payload, B/R readies
//   slave  - drives AW/W/AR readies, B/R valids + payload
interface axi_lite_cmd_master_if;
  // AW channel
  logic        AxiWriteAddrValid_ValOut;
  logic        AxiWriteAddrReady_RdyIn;
  logic [15:0] AxiWriteAddrAddress_AdrOut;
  logic [2:0]  AxiWriteAddrProt_DatOut;
  // W channel
  logic        AxiWriteDataValid_ValOut;
  logic        AxiWriteDataReady_RdyIn;
  logic [31:0] AxiWriteDataData_DatOut;
  logic [3:0]  AxiWriteDataStrobe_DatOut;
  // B channel
  logic        AxiWriteRespValid_ValIn;
  logic        AxiWriteRespReady_RdyOut;
  logic [1:0]  AxiWriteRespResponse_DatIn;
  // AR channel
  logic        AxiReadAddrValid_ValOut;
  logic        AxiReadAddrReady_RdyIn;
  logic [15:0] AxiReadAddrAddress_AdrOut;
  logic [2:0]  AxiReadAddrProt_DatOut;
  // R channel
  logic        AxiReadDataValid_ValIn;
  logic        AxiReadDataReady_RdyOut;
  logic [1:0]  AxiReadDataResponse_DatIn;
  logic [31:0] AxiReadDataData_DatIn;

  modport master (
    output AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
    input  AxiWriteAddrReady_RdyIn,
    output AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
    input  AxiWriteDataReady_RdyIn,
    input  AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn,
    output AxiWriteRespReady_RdyOut,
    output AxiReadAddrValid_ValOut, AxiReadAddrAddress_AdrOut, AxiReadAddrProt_DatOut,
    input  AxiReadAddrReady_RdyIn,
    input  AxiReadDataValid_ValIn, AxiReadDataResponse_DatIn, AxiReadDataData_DatIn,
    output AxiReadDataReady_RdyOut
  );

  modport slave (
    input  AxiWriteAddrValid_ValOut, AxiWriteAddrAddress_AdrOut, AxiWriteAddrProt_DatOut,
    output AxiWriteAddrReady_RdyIn,
    input  AxiWriteDataValid_ValOut, AxiWriteDataData_DatOut, AxiWriteDataStrobe_DatOut,
    output AxiWriteDataReady_RdyIn,
    output AxiWriteRespValid_ValIn, AxiWriteRespResponse_DatIn,
    input  AxiWriteRespReady_RdyOut,
    input  AxiReadAddrValid_ValOut, AxiReadAddrAddress_AdrOut, AxiReadAddrProt_DatOut,
    output AxiReadAddrReady_RdyIn,
    output AxiReadDataValid_ValIn, AxiReadDataResponse_DatIn, AxiReadDataData_DatIn,
    input  AxiReadDataReady_RdyOut
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns single-beat register commands into AXI4-Lite
// transactions, one outstanding at a time. A bus-hang timeout returns an
// error response (SLVERR, RspTimeout=1) instead of locking the requester.
// Ports:
//   SysClk_ClkIn / SysRst_RstIn   clock, synchronous active-high reset
//   Cmd*                          command request (valid/ready, write, addr, data, strobe)
//   Rsp*                          response (valid/ready, read data, resp code, timeout flag)
//   axi                           AXI4-Lite master side (AW, W, B, AR, R)
// Parameter:
//   TimeoutCycles_Gen             busy cycles allowed per transaction, 0 = no timeout
module axi_lite_cmd_master #(
  parameter int unsigned TimeoutCycles_Gen = 1024
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRst_RstIn,
  input  logic        CmdValid_ValIn,
  output logic        CmdReady_RdyOut,
  input  logic        CmdWrite_EnaIn,
  input  logic [15:0] CmdAddress_AdrIn,
  input  logic [31:0] CmdData_DatIn,
  input  logic [3:0]  CmdStrobe_DatIn,
  output logic        RspValid_ValOut,
  input  logic        RspReady_RdyIn,
  output logic [31:0] RspData_DatOut,
  output logic [1:0]  RspResponse_DatOut,
  output logic        RspTimeout_DatOut,
  axi_lite_cmd_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  localparam bit          ToEna   = (TimeoutCycles_Gen != 0);
  // Timeout fires in the busy cycle whose count reaches the limit, i.e. when
  // the pre-increment count is one below it.
  localparam logic [31:0] ToLimit = ToEna ? 32'(TimeoutCycles_Gen - 1) : 32'd0;

  state_t      state;
  logic [31:0] toCnt;
  logic        busy, bHs, rHs, done, toHit, awFin, wFin;

  assign axi.AxiWriteAddrProt_DatOut = 3'b000;
  assign axi.AxiReadAddrProt_DatOut  = 3'b000;

  always_comb begin
    busy  = (state == WR_AW_W) || (state == WR_B) || (state == RD_AR) || (state == RD_R);
    bHs   = axi.AxiWriteRespValid_ValIn & axi.AxiWriteRespReady_RdyOut;
    rHs   = axi.AxiReadDataValid_ValIn & axi.AxiReadDataReady_RdyOut;
    done  = ((state == WR_B) && bHs) || ((state == RD_R) && rHs);
    // A completing handshake in the timeout cycle takes priority.
    toHit = ToEna && busy && (toCnt >= ToLimit) && !done;
    // A channel is finished once its valid is gone or it handshakes now.
    awFin = !axi.AxiWriteAddrValid_ValOut || axi.AxiWriteAddrReady_RdyIn;
    wFin  = !axi.AxiWriteDataValid_ValOut || axi.AxiWriteDataReady_RdyIn;
  end

  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      state                          <= IDLE;
      toCnt                          <= '0;
      CmdReady_RdyOut                <= 1'b1;
      RspValid_ValOut                <= 1'b0;
      RspData_DatOut                 <= '0;
      RspResponse_DatOut             <= '0;
      RspTimeout_DatOut              <= 1'b0;
      axi.AxiWriteAddrValid_ValOut   <= 1'b0;
      axi.AxiWriteAddrAddress_AdrOut <= '0;
      axi.AxiWriteDataValid_ValOut   <= 1'b0;
      axi.AxiWriteDataData_DatOut    <= '0;
      axi.AxiWriteDataStrobe_DatOut  <= '0;
      axi.AxiWriteRespReady_RdyOut   <= 1'b0;
      axi.AxiReadAddrValid_ValOut    <= 1'b0;
      axi.AxiReadAddrAddress_AdrOut  <= '0;
      axi.AxiReadDataReady_RdyOut    <= 1'b0;
    end else begin
      if (busy && toCnt != '1) toCnt <= toCnt + 32'd1;

      if (toHit) begin
        axi.AxiWriteAddrValid_ValOut <= 1'b0;
        axi.AxiWriteDataValid_ValOut <= 1'b0;
        axi.AxiWriteRespReady_RdyOut <= 1'b0;
        axi.AxiReadAddrValid_ValOut  <= 1'b0;
        axi.AxiReadDataReady_RdyOut  <= 1'b0;
        RspValid_ValOut              <= 1'b1;
        RspData_DatOut               <= '0;
        RspResponse_DatOut           <= 2'b10;
        RspTimeout_DatOut            <= 1'b1;
        state                        <= RSP;
      end else begin
        case (state)
          IDLE: begin
            if (CmdValid_ValIn && CmdReady_RdyOut) begin
              CmdReady_RdyOut <= 1'b0;
              toCnt           <= '0;
              if (CmdWrite_EnaIn) begin
                axi.AxiWriteAddrAddress_AdrOut <= CmdAddress_AdrIn;
                axi.AxiWriteDataData_DatOut    <= CmdData_DatIn;
                axi.AxiWriteDataStrobe_DatOut  <= CmdStrobe_DatIn;
                axi.AxiWriteAddrValid_ValOut   <= 1'b1;
                axi.AxiWriteDataValid_ValOut   <= 1'b1;
                state                          <= WR_AW_W;
              end else begin
                axi.AxiReadAddrAddress_AdrOut <= CmdAddress_AdrIn;
                axi.AxiReadAddrValid_ValOut   <= 1'b1;
                state                         <= RD_AR;
              end
            end
          end
          WR_AW_W: begin
            if (axi.AxiWriteAddrReady_RdyIn) axi.AxiWriteAddrValid_ValOut <= 1'b0;
            if (axi.AxiWriteDataReady_RdyIn) axi.AxiWriteDataValid_ValOut <= 1'b0;
            if (awFin && wFin) begin
              axi.AxiWriteRespReady_RdyOut <= 1'b1;
              state                        <= WR_B;
            end
          end
          WR_B: begin
            if (bHs) begin
              axi.AxiWriteRespReady_RdyOut <= 1'b0;
              RspValid_ValOut              <= 1'b1;
              RspData_DatOut               <= '0;
              RspResponse_DatOut           <= axi.AxiWriteRespResponse_DatIn;
              RspTimeout_DatOut            <= 1'b0;
              state                        <= RSP;
            end
          end
          RD_AR: begin
            if (axi.AxiReadAddrReady_RdyIn) begin
              axi.AxiReadAddrValid_ValOut <= 1'b0;
              axi.AxiReadDataReady_RdyOut <= 1'b1;
              state                       <= RD_R;
            end
          end
          RD_R: begin
            if (rHs) begin
              axi.AxiReadDataReady_RdyOut <= 1'b0;
              RspValid_ValOut             <= 1'b1;
              RspData_DatOut              <= axi.AxiReadDataData_DatIn;
              RspResponse_DatOut          <= axi.AxiReadDataResponse_DatIn;
              RspTimeout_DatOut           <= 1'b0;
              state                       <= RSP;
            end
          end
          RSP: begin
            if (RspReady_RdyIn) begin
              RspValid_ValOut <= 1'b0;
              CmdReady_RdyOut <= 1'b1;
              state           <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
module tb_axi_lite_cmd_master;
  localparam int To = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmdValid, cmdReady, cmdWrite;
  logic [15:0] cmdAdr;
  logic [31:0] cmdDat;
  logic [3:0]  cmdStrb;
  logic        rspValid, rspReady, rspTo;
  logic [31:0] rspDat;
  logic [1:0]  rspResp;
  int          errs = 0;
  int          checks = 0;

  axi_lite_cmd_master_if bus();

  axi_lite_cmd_master #(.TimeoutCycles_Gen(To)) dut (
    .SysClk_ClkIn(clk), .SysRst_RstIn(rst),
    .CmdValid_ValIn(cmdValid), .CmdReady_RdyOut(cmdReady), .CmdWrite_EnaIn(cmdWrite),
    .CmdAddress_AdrIn(cmdAdr), .CmdData_DatIn(cmdDat), .CmdStrobe_DatIn(cmdStrb),
    .RspValid_ValOut(rspValid), .RspReady_RdyIn(rspReady), .RspData_DatOut(rspDat),
    .RspResponse_DatOut(rspResp), .RspTimeout_DatOut(rspTo), .axi(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic slaveIdle();
    bus.AxiWriteAddrReady_RdyIn   = 0;
    bus.AxiWriteDataReady_RdyIn   = 0;
    bus.AxiWriteRespValid_ValIn   = 0;
    bus.AxiWriteRespResponse_DatIn = 0;
    bus.AxiReadAddrReady_RdyIn    = 0;
    bus.AxiReadDataValid_ValIn    = 0;
    bus.AxiReadDataResponse_DatIn = 0;
    bus.AxiReadDataData_DatIn     = 0;
  endtask

  // Outputs as one vector: {aw, w, b, ar, r, cmdReady, rspValid}
  function automatic logic [6:0] outVec();
    return {bus.AxiWriteAddrValid_ValOut, bus.AxiWriteDataValid_ValOut, bus.AxiWriteRespReady_RdyOut,
            bus.AxiReadAddrValid_ValOut, bus.AxiReadDataReady_RdyOut, cmdReady, rspValid};
  endfunction

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  // Cycle c counts from the accept cycle (c=0). Slave readies rise at cycle
  // 1+dA / 1+dW; B/R valid rises dB cycles after the master starts waiting.
  task automatic runTxn(input bit wr, input logic [15:0] adr, input logic [31:0] dat,
                        input logic [3:0] strb, input int dA, input int dW, input int dB,
                        input logic [1:0] resp, input logic [31:0] rdat, input int hold);
    int  waitC, cB, endC;
    bit  to;
    logic [31:0] expDat;
    logic [1:0]  expResp;
    waitC = wr ? 2 + ((dA > dW) ? dA : dW) : 2 + dA;
    cB    = waitC + dB;
    to    = cB > To;
    endC  = to ? To : cB;
    expDat  = (to || wr) ? 32'd0 : rdat;
    expResp = to ? 2'b10 : resp;

    chk("idleCmdReady", cmdReady, 1'b1);
    cmdValid = 1; cmdWrite = wr; cmdAdr = adr; cmdDat = dat; cmdStrb = strb;
    for (int c = 1; c <= endC; c++) begin
      logic [6:0] e;
      @(posedge clk); #1;
      cmdValid = 0; cmdAdr = 16'($urandom); cmdDat = $urandom; cmdStrb = 4'($urandom);
      cmdWrite = 1'($urandom);
      rspReady = 1'($urandom);
      e = {wr && c <= 1 + dA, wr && c <= 1 + dW, wr && c >= waitC,
           !wr && c <= 1 + dA, !wr && c >= waitC, 1'b0, 1'b0};
      if (wr && (e[6] || e[5])) begin
        if (c > 1 + dA) e[6] = 0;
      end
      chk("busy", outVec(), e);
      if (e[6]) chk("awAddr", bus.AxiWriteAddrAddress_AdrOut, adr);
      if (e[5]) chk("wData", {bus.AxiWriteDataStrobe_DatOut, bus.AxiWriteDataData_DatOut}, {strb, dat});
      if (e[3]) chk("arAddr", bus.AxiReadAddrAddress_AdrOut, adr);
      if (wr) begin
        bus.AxiWriteAddrReady_RdyIn    = c >= 1 + dA;
        bus.AxiWriteDataReady_RdyIn    = c >= 1 + dW;
        bus.AxiWriteRespValid_ValIn    = c >= cB;
        bus.AxiWriteRespResponse_DatIn = resp;
        bus.AxiReadDataValid_ValIn     = 1;  // stray R beat must be ignored
        bus.AxiReadDataData_DatIn      = $urandom;
        bus.AxiReadDataResponse_DatIn  = 2'($urandom);
      end else begin
        bus.AxiReadAddrReady_RdyIn     = c >= 1 + dA;
        bus.AxiReadDataValid_ValIn     = c >= cB;
        bus.AxiReadDataData_DatIn      = rdat;
        bus.AxiReadDataResponse_DatIn  = resp;
        bus.AxiWriteRespValid_ValIn    = 1;  // stray B beat must be ignored
        bus.AxiWriteRespResponse_DatIn = 2'($urandom);
      end
    end
    for (int j = 0; j <= hold; j++) begin
      @(posedge clk); #1;
      slaveIdle();
      chk("rspVec", outVec(), 7'b0000001);
      chk("rspPayload", {rspTo, rspResp, rspDat}, {to, expResp, expDat});
      rspReady = (j == hold);
    end
    @(posedge clk); #1;
    rspReady = 0;
    chk("afterRsp", outVec(), 7'b0000010);
  endtask

  initial begin
    rst = 1; cmdValid = 0; cmdWrite = 0; cmdAdr = 0; cmdDat = 0; cmdStrb = 0; rspReady = 0;
    slaveIdle();
    repeat (3) @(posedge clk);
    #1;
    chk("rstVec", outVec(), 7'b0000010);
    chk("rstPayload", {rspTo, rspResp, rspDat}, 35'd0);
    chk("rstAddr", {bus.AxiWriteAddrAddress_AdrOut, bus.AxiReadAddrAddress_AdrOut,
                    bus.AxiWriteDataData_DatOut, bus.AxiWriteDataStrobe_DatOut}, 64'd0);
    chk("prot", {bus.AxiWriteAddrProt_DatOut, bus.AxiReadAddrProt_DatOut}, 6'd0);
    rst = 0;
    @(posedge clk); #1;

    // Directed cases
    runTxn(1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, 0);
    runTxn(0, 16'h0000, 0, 0, 4, 0, 0, 2'b00, 32'h000A0000, 0);
    runTxn(1, 16'h0010, 32'h12345678, 4'h3, 1, 5, 2, 2'b01, 0, 0);
    runTxn(1, 16'h0020, 32'h0, 4'h0, 7, 1, 0, 2'b00, 0, 0);
    runTxn(0, 16'h0044, 0, 0, 100, 0, 0, 2'b00, 32'h5555AAAA, 0);
    runTxn(0, 16'h0048, 0, 0, 0, 0, 14, 2'b11, 32'hCAFEF00D, 0);  // completes on timeout cycle
    runTxn(0, 16'h004C, 0, 0, 0, 0, 15, 2'b00, 32'hCAFEF00D, 0);  // one cycle late
    runTxn(1, 16'h0050, 32'hA5A5A5A5, 4'hC, 0, 0, 0, 2'b10, 0, 10);
    runTxn(0, 16'h0054, 0, 0, 0, 0, 0, 2'b00, 32'h01020304, 0);

    // Reset while waiting for B
    chk("preRstRdy", cmdReady, 1'b1);
    cmdValid = 1; cmdWrite = 1; cmdAdr = 16'h0060; cmdDat = 32'h11112222; cmdStrb = 4'hF;
    bus.AxiWriteAddrReady_RdyIn = 1; bus.AxiWriteDataReady_RdyIn = 1;
    @(posedge clk); #1;
    cmdValid = 0;
    @(posedge clk); #1;
    chk("inWrB", outVec(), 7'b0010000);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; slaveIdle();
    chk("midRstVec", outVec(), 7'b0000010);
    chk("midRstPayload", {rspTo, rspResp, rspDat, bus.AxiWriteAddrAddress_AdrOut}, 51'd0);
    @(posedge clk); #1;
    chk("postRstVec", outVec(), 7'b0000010);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int gap;
      runTxn(1'($urandom), 16'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8),
             2'($urandom), $urandom, $urandom_range(0, 3));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("gapIdle", outVec(), 7'b0000010);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    errs++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end
endmodule
